// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: bus register offsets,
// FSM state encodings and source mode bit values.
package irq_ctrl_pkg;

  localparam int DEV_ADDR_WD = 4;

  localparam logic [DEV_ADDR_WD-1:0] IRQ_REG_CTRL = 4'd0;
  localparam logic [DEV_ADDR_WD-1:0] IRQ_REG_MASK = 4'd1;
  localparam logic [DEV_ADDR_WD-1:0] IRQ_REG_PEND = 4'd2;
  localparam logic [DEV_ADDR_WD-1:0] IRQ_REG_MODE = 4'd3;
  localparam logic [DEV_ADDR_WD-1:0] IRQ_REG_ISR  = 4'd4;

  localparam logic IRQ_MODE_EDGE  = 1'b1;
  localparam logic IRQ_MODE_LEVEL = 1'b0;

  typedef enum logic [1:0] {
    IRQ_ST_IDLE    = 2'd0,
    IRQ_ST_REQ     = 2'd1,
    IRQ_ST_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: returns the index of the lowest set request bit
// together with a flag that any bit is set.
module irq_prio_enc #(
  parameter int N_SRC = 6,
  parameter int ID_W  = 3
) (
  input  logic [N_SRC-1:0] req,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  // Scan from the top so the lowest set index is the last one written
  always_comb begin
    id    = {ID_W{1'b0}};
    valid = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      id    = req[i] ? ID_W'(i) : id;
      valid = valid | req[i];
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Bus-mapped interrupt controller: latches device irq lines as pending,
// applies mask and fixed priority, and holds one in-service source until EOI.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC = 6,
  parameter int ID_W  = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DEV_ADDR_WD:1]   add_i,
  input  logic                   we_i,
  input  logic [31:0]            dat_i,
  output logic [31:0]            dat_o,
  input  logic [N_SRC-1:0]       irq_src_i,
  input  logic                   ack_i,
  output logic                   irq_o,
  output logic [N_SRC-1:0]       hwint_o
);

  logic             ctrl_r;
  logic [N_SRC-1:0] mask_r;
  logic [N_SRC-1:0] mode_r;
  logic [N_SRC-1:0] pend_r;
  logic [N_SRC-1:0] prev_r;
  logic [N_SRC-1:0] act_r;
  logic             isr_valid_r;
  logic [ID_W-1:0]  isr_id_r;
  irq_state_e       state_r;
  irq_state_e       state_next_s;

  logic [N_SRC-1:0] act_s;
  logic [N_SRC-1:0] edge_sel_s;
  logic [N_SRC-1:0] edge_set_s;
  logic [N_SRC-1:0] w1c_s;
  logic [N_SRC-1:0] ack_clr_s;
  logic [N_SRC-1:0] pend_edge_s;
  logic [N_SRC-1:0] pend_next_s;
  logic [ID_W-1:0]  enc_id_s;
  logic             enc_valid_s;
  logic             wr_ctrl_s;
  logic             wr_mask_s;
  logic             wr_pend_s;
  logic             wr_mode_s;
  logic             eoi_s;
  logic             take_s;
  logic             unused_dat_s;

  assign unused_dat_s = ^dat_i[31:N_SRC];

  assign wr_ctrl_s = we_i && (add_i == IRQ_REG_CTRL);
  assign wr_mask_s = we_i && (add_i == IRQ_REG_MASK);
  assign wr_pend_s = we_i && (add_i == IRQ_REG_PEND);
  assign wr_mode_s = we_i && (add_i == IRQ_REG_MODE);
  assign eoi_s     = we_i && (add_i == IRQ_REG_ISR) && (state_r == IRQ_ST_SERVICE);
  assign take_s    = (state_r == IRQ_ST_REQ) && ack_i && enc_valid_s;

  irq_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .req   (act_r),
    .id    (enc_id_s),
    .valid (enc_valid_s)
  );

  // Pending update: a new edge beats both W1C and the clear-on-acknowledge
  assign act_s       = pend_r & mask_r & {N_SRC{ctrl_r}};
  assign edge_sel_s  = mode_r ^ {N_SRC{IRQ_MODE_LEVEL}};
  assign edge_set_s  = irq_src_i & ~prev_r;
  assign w1c_s       = wr_pend_s ? dat_i[N_SRC-1:0] : {N_SRC{1'b0}};
  assign ack_clr_s   = take_s ? ({{(N_SRC-1){1'b0}}, 1'b1} << enc_id_s) : {N_SRC{1'b0}};
  assign pend_edge_s = (pend_r & ~w1c_s & ~ack_clr_s) | edge_set_s;
  assign pend_next_s = (edge_sel_s & pend_edge_s) | (~edge_sel_s & irq_src_i);

  assign hwint_o = act_r;

  // Next-state logic for the request/service handshake
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IRQ_ST_IDLE: begin
        if (enc_valid_s) begin
          state_next_s = IRQ_ST_REQ;
        end else begin
          state_next_s = IRQ_ST_IDLE;
        end
      end
      IRQ_ST_REQ: begin
        if (!enc_valid_s) begin
          state_next_s = IRQ_ST_IDLE;
        end else if (ack_i) begin
          state_next_s = IRQ_ST_SERVICE;
        end else begin
          state_next_s = IRQ_ST_REQ;
        end
      end
      IRQ_ST_SERVICE: begin
        if (eoi_s) begin
          state_next_s = IRQ_ST_IDLE;
        end else begin
          state_next_s = IRQ_ST_SERVICE;
        end
      end
      default: state_next_s = IRQ_ST_IDLE;
    endcase
  end

  // Control registers, pending/edge state, in-service record and FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_r      <= 1'b0;
      mask_r      <= {N_SRC{1'b0}};
      mode_r      <= {N_SRC{1'b0}};
      pend_r      <= {N_SRC{1'b0}};
      prev_r      <= {N_SRC{1'b0}};
      act_r       <= {N_SRC{1'b0}};
      isr_valid_r <= 1'b0;
      isr_id_r    <= {ID_W{1'b0}};
      state_r     <= IRQ_ST_IDLE;
      irq_o       <= 1'b0;
    end else begin
      if (wr_ctrl_s) ctrl_r <= dat_i[0];
      if (wr_mask_s) mask_r <= dat_i[N_SRC-1:0];
      if (wr_mode_s) mode_r <= dat_i[N_SRC-1:0];
      prev_r  <= irq_src_i;
      pend_r  <= pend_next_s;
      act_r   <= act_s;
      state_r <= state_next_s;
      irq_o   <= (state_next_s == IRQ_ST_REQ);
      if (take_s) begin
        isr_valid_r <= 1'b1;
        isr_id_r    <= enc_id_s;
      end else if (eoi_s) begin
        isr_valid_r <= 1'b0;
      end
    end
  end

  // Registered read mux, one cycle behind the address
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dat_o <= 32'd0;
    end else begin
      case (add_i)
        IRQ_REG_CTRL: dat_o <= {31'd0, ctrl_r};
        IRQ_REG_MASK: dat_o <= {{(32-N_SRC){1'b0}}, mask_r};
        IRQ_REG_PEND: dat_o <= {{(32-N_SRC){1'b0}}, pend_r};
        IRQ_REG_MODE: dat_o <= {{(32-N_SRC){1'b0}}, mode_r};
        IRQ_REG_ISR:  dat_o <= {isr_valid_r, {(31-ID_W){1'b0}}, isr_id_r};
        default:      dat_o <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: hand-computed register reads and irq timing.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int N_SRC = 6;
  localparam int ID_W  = 3;

  logic                 clk;
  logic                 rst;
  logic [DEV_ADDR_WD:1] add;
  logic                 we;
  logic [31:0]          wdat;
  logic [31:0]          rdat;
  logic [N_SRC-1:0]     src;
  logic                 ack;
  logic                 irq;
  logic [N_SRC-1:0]     hwint;

  int n_vec;
  int n_err;

  irq_ctrl #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .add_i     (add),
    .we_i      (we),
    .dat_i     (wdat),
    .dat_o     (rdat),
    .irq_src_i (src),
    .ack_i     (ack),
    .irq_o     (irq),
    .hwint_o   (hwint)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All bus tasks start and end on a falling edge
  task automatic bus_wr(input logic [DEV_ADDR_WD-1:0] a, input logic [31:0] d);
    add = a; wdat = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0; wdat = 32'd0;
  endtask

  task automatic bus_rd(input logic [DEV_ADDR_WD-1:0] a, output logic [31:0] d);
    add = a; we = 1'b0;
    @(negedge clk);
    d = rdat;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_irq;
    for (int i = 0; i < 10 && irq !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic pulse_ack;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    for (int r = 0; r < 5; r++) begin
      bus_rd(DEV_ADDR_WD'(r), v);
      n_vec++;
      if (v !== 32'd0) begin
        n_err++; $display("FAIL reset_read[%0d]: got %h want 00000000", r, v);
      end
    end
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_vec++;
    if (hwint !== 6'h00) begin n_err++; $display("FAIL reset_hwint: got %h want 00", hwint); end
  endtask

  task automatic test_edge_basic;
    logic [31:0] v;
    bus_wr(IRQ_REG_MASK, 32'h1);
    bus_wr(IRQ_REG_MODE, {31'd0, IRQ_MODE_EDGE});
    bus_wr(IRQ_REG_CTRL, 32'h1);
    src[0] = 1'b1;
    @(negedge clk);
    src[0] = 1'b0;
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL edge_lat1: got %b want 0", irq); end
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL edge_lat2: got %b want 0", irq); end
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL edge_lat3: got %b want 1", irq); end
    bus_rd(IRQ_REG_PEND, v);
    n_vec++;
    if (v !== 32'h1) begin n_err++; $display("FAIL edge_pend: got %h want 00000001", v); end
    n_vec++;
    if (hwint !== 6'h01) begin n_err++; $display("FAIL edge_hwint: got %h want 01", hwint); end
    pulse_ack();
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL edge_ack_irq: got %b want 0", irq); end
    bus_rd(IRQ_REG_ISR, v);
    n_vec++;
    if (v !== 32'h8000_0000) begin n_err++; $display("FAIL edge_isr: got %h want 80000000", v); end
    bus_rd(IRQ_REG_PEND, v);
    n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL edge_pend_clr: got %h want 00000000", v); end
    bus_wr(IRQ_REG_ISR, 32'h0);
    bus_rd(IRQ_REG_ISR, v);
    n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL edge_eoi: got %h want 00000000", v); end
    cycles(3);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL edge_idle: got %b want 0", irq); end
  endtask

  task automatic test_level_prio;
    logic [31:0] v;
    bus_wr(IRQ_REG_MODE, 32'h0);
    bus_wr(IRQ_REG_MASK, 32'h14);
    src[2] = 1'b1; src[4] = 1'b1;
    wait_irq();
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL lvl_req: got %b want 1", irq); end
    pulse_ack();
    bus_rd(IRQ_REG_ISR, v);
    n_vec++;
    if (v !== 32'h8000_0002) begin n_err++; $display("FAIL lvl_isr2: got %h want 80000002", v); end
    src[2] = 1'b0;
    bus_wr(IRQ_REG_ISR, 32'h0);
    wait_irq();
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL lvl_rereq: got %b want 1", irq); end
    pulse_ack();
    bus_rd(IRQ_REG_ISR, v);
    n_vec++;
    if (v !== 32'h8000_0004) begin n_err++; $display("FAIL lvl_isr4: got %h want 80000004", v); end
    src[4] = 1'b0;
    bus_wr(IRQ_REG_ISR, 32'h0);
    cycles(3);
    n_vec++;
    if (irq !== 1'b0 || hwint !== 6'h00) begin
      n_err++; $display("FAIL lvl_quiet: got irq=%b hwint=%h want 0/00", irq, hwint);
    end
  endtask

  task automatic test_w1c_race;
    logic [31:0] v;
    bus_wr(IRQ_REG_MASK, 32'h0);
    bus_wr(IRQ_REG_MODE, 32'h02);
    src[1] = 1'b1;
    bus_wr(IRQ_REG_PEND, 32'h02);
    src[1] = 1'b0;
    bus_rd(IRQ_REG_PEND, v);
    n_vec++;
    if (v !== 32'h02) begin n_err++; $display("FAIL w1c_race: got %h want 00000002", v); end
    bus_wr(IRQ_REG_PEND, 32'h02);
    bus_rd(IRQ_REG_PEND, v);
    n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL w1c_clear: got %h want 00000000", v); end
  endtask

  task automatic test_level_drop;
    logic [31:0] v;
    bus_wr(IRQ_REG_MODE, 32'h0);
    bus_wr(IRQ_REG_MASK, 32'h08);
    src[3] = 1'b1;
    wait_irq();
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL drop_req: got %b want 1", irq); end
    src[3] = 1'b0;
    cycles(3);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL drop_fall: got %b want 0", irq); end
    pulse_ack();
    cycles(2);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL drop_ack_irq: got %b want 0", irq); end
    bus_rd(IRQ_REG_ISR, v);
    n_vec++;
    if (v !== 32'h4) begin n_err++; $display("FAIL drop_isr: got %h want 00000004", v); end
  endtask

  task automatic test_service_hold;
    logic [31:0] v;
    bus_wr(IRQ_REG_MODE, 32'h01);
    bus_wr(IRQ_REG_MASK, 32'h01);
    src[0] = 1'b1;
    @(negedge clk);
    src[0] = 1'b0;
    wait_irq();
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL svc_req: got %b want 1", irq); end
    pulse_ack();
    src[0] = 1'b1;
    @(negedge clk);
    src[0] = 1'b0;
    cycles(3);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL svc_nonest: got %b want 0", irq); end
    n_vec++;
    if (hwint !== 6'h01) begin n_err++; $display("FAIL svc_hwint: got %h want 01", hwint); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 5; r++) begin
      bus_rd(DEV_ADDR_WD'(r), v);
      n_vec++;
      if (v !== 32'd0) begin
        n_err++; $display("FAIL svc_rst_read[%0d]: got %h want 00000000", r, v);
      end
    end
    n_vec++;
    if (irq !== 1'b0 || hwint !== 6'h00) begin
      n_err++; $display("FAIL svc_rst_out: got irq=%b hwint=%h want 0/00", irq, hwint);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; add = '0; we = 1'b0; wdat = 32'd0; src = '0; ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_edge_basic();
    test_level_prio();
    test_w1c_race();
    test_level_drop();
    test_service_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

endmodule
